instruction_fetch: RTL

Pipeline IF stage plus IF/ID latch, directly upstream of the decode stage. Holds the PC and a debug-loadable instruction memory. Each enabled cycle it fetches one word and presents {instruction, PC+1} to decode. It obeys decode's stall, redirect and halt outputs.

---
 rtl/instruction_fetch_pkg.sv | 21 ++
 rtl/instruction_memory.sv | 24 ++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int ADDRWIDTH = 8;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SRC_NEXT   = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_REG    = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory: synchronous write, asynchronous read.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clock,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    logic [NB_DATA-1:0] mem [0:(1 << NB_ADDR)-1];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID latch. Optional macro FETCH_FLUSH_EN makes a taken
// redirect flush IF/ID (no delay slot); default build keeps one delay slot.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = ADDRWIDTH
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_pc_write,
    input  logic               i_IF_ID_write,
    input  logic               i_branch_or_jump,
    input  logic [1:0]         i_pc_src,
    input  logic [NB_ADDR-1:0] i_addr_branch,
    input  logic [NB_ADDR-1:0] i_addr_jump,
    input  logic [NB_ADDR-1:0] i_addr_register,
    input  logic               i_halt,
    input  logic               i_wr_mem,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_pc,
    output logic [NB_ADDR-1:0] o_pc_current,
    output logic               o_halted
);

    fetch_state_t       state;
    logic [NB_ADDR-1:0] pc;
    logic [NB_ADDR-1:0] pc_next;
    logic [NB_ADDR-1:0] pc_target;
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] if_id_instruction;
    logic [NB_ADDR-1:0] if_id_pc;
    logic               halted;
    logic               mem_wr_en;

    // Program loading is only accepted while the stage is idle.
    assign mem_wr_en = i_wr_mem && (state == IDLE);

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_instruction_memory (
        .i_clock   (i_clock),
        .i_wr_en   (mem_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (pc),
        .o_rd_data (fetch_word)
    );

    always_comb begin
        pc_next   = pc + NB_ADDR'(1);
        pc_target = pc_next;
        case (pc_src_t'(i_pc_src))
            PC_SRC_BRANCH: pc_target = i_addr_branch;
            PC_SRC_JUMP:   pc_target = i_addr_jump;
            PC_SRC_REG:    pc_target = i_addr_register;
            default:       pc_target = pc_next;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state             <= IDLE;
            pc                <= '0;
            if_id_instruction <= '0;
            if_id_pc          <= '0;
            halted            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable && !i_wr_mem) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_enable) begin
                        if (i_halt) begin
                            if_id_instruction <= NB_DATA'(NOP);
                            if_id_pc          <= '0;
                            halted            <= 1'b1;
                            state             <= HALTED;
                        end else if (!i_pc_write) begin
                            // Stall drops any redirect; decode re-asserts it.
                            if (i_IF_ID_write) begin
                                if_id_instruction <= fetch_word;
                                if_id_pc          <= pc_next;
                            end
                        end else if (i_branch_or_jump) begin
                            pc <= pc_target;
`ifdef FETCH_FLUSH_EN
                            if_id_instruction <= NB_DATA'(NOP);
                            if_id_pc          <= '0;
`else
                            if (i_IF_ID_write) begin
                                if_id_instruction <= fetch_word;
                                if_id_pc          <= pc_next;
                            end
`endif
                        end else begin
                            pc <= pc_next;
                            if (i_IF_ID_write) begin
                                if_id_instruction <= fetch_word;
                                if_id_pc          <= pc_next;
                            end
                        end
                    end
                end
                HALTED: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_instruction = if_id_instruction;
    assign o_pc          = if_id_pc;
    assign o_pc_current  = pc;
    assign o_halted      = halted;

endmodule
